// File: rtl/fft_stage_counter.sv
// ============================================================================
// fft_stage_counter : valid-qualified sample/stage counter for the FFT
// datapath with wrap/done pulses and a bit-reversed sample index.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_stage_counter #(
  parameter int CNT_W = 8,
  parameter int STG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             valid,
  input  logic [CNT_W-1:0] thresh,
  input  logic [STG_W-1:0] num_stages,
  output logic             busy,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_rev,
  output logic [STG_W-1:0] stage,
  output logic             not_zero,
  output logic             wrap,
  output logic             done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STG_W-1:0] STG_ONE = {{(STG_W-1){1'b0}}, 1'b1};

  logic [0:0]       state_q,    state_d;
  logic [CNT_W-1:0] thresh_q,   thresh_d;
  logic [STG_W-1:0] stages_q,   stages_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [STG_W-1:0] stage_q,    stage_d;
  logic             wrap_q,     wrap_d;
  logic             done_q,     done_d;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      thresh_q <= '0;
      stages_q <= '0;
      cnt_q    <= '0;
      stage_q  <= '0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      thresh_q <= thresh_d;
      stages_q <= stages_d;
      cnt_q    <= cnt_d;
      stage_q  <= stage_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d  = state_q;
    thresh_d = thresh_q;
    stages_d = stages_q;
    cnt_d    = cnt_q;
    stage_d  = stage_q;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          thresh_d = thresh;
          stages_d = num_stages;
          cnt_d    = '0;
          stage_d  = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          cnt_d   = '0;
          stage_d = '0;
          state_d = ST_IDLE;
        end else if (valid) begin
          if (cnt_q == thresh_q) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
            if (stage_q == stages_q) begin
              done_d  = 1'b1;
              stage_d = '0;
              state_d = ST_IDLE;
            end else begin
              stage_d = stage_q + STG_ONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: all registered except the cnt-derived decodes
  always_comb begin
    busy     = (state_q == ST_RUN);
    cnt      = cnt_q;
    stage    = stage_q;
    wrap     = wrap_q;
    done     = done_q;
    not_zero = |cnt_q;
  end

  for (genvar i = 0; i < CNT_W; i++) begin : g_rev
    assign cnt_rev[i] = cnt_q[CNT_W-1-i];
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_stage_counter.sv
// Testbench for fft_stage_counter: directed vector table, corner sequences
// and random stimulus checked against a frame-arithmetic reference model.
`default_nettype none

module tb_fft_stage_counter;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, valid;
  logic [7:0] thresh;
  logic [2:0] num_stages;
  logic       busy, not_zero, wrap, done;
  logic [7:0] cnt, cnt_rev;
  logic [2:0] stage;

  always #5 clk = ~clk;

  fft_stage_counter #(.CNT_W(8), .STG_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .valid(valid),
    .thresh(thresh), .num_stages(num_stages), .busy(busy), .cnt(cnt),
    .cnt_rev(cnt_rev), .stage(stage), .not_zero(not_zero), .wrap(wrap),
    .done(done)
  );

  int checks = 0;
  int errors = 0;

  // Model: a transform is (ns+1) frames of len samples; position is total samples taken
  bit m_run, m_wrap, m_done;
  int m_total, m_len, m_ns;

  typedef struct {
    bit rst_n, start, abort, valid;
    int thr, ns;
    int e_busy, e_cnt, e_stage, e_wrap, e_done;
  } vec_t;

  function automatic int rev8(input int c);
    int r = 0;
    for (int i = 0; i < 8; i++) if (((c >> i) & 1) != 0) r |= (1 << (7 - i));
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_run = 0; m_total = 0; m_wrap = 0; m_done = 0;
    end else begin
      m_wrap = 0; m_done = 0;
      if (!m_run) begin
        if (start && !abort) begin
          m_run = 1; m_total = 0; m_len = int'(thresh) + 1; m_ns = int'(num_stages);
        end
      end else if (abort) begin
        m_run = 0; m_total = 0;
      end else if (valid) begin
        m_total++;
        if (m_total % m_len == 0) m_wrap = 1;
        if (m_total == m_len * (m_ns + 1)) begin
          m_done = 1; m_run = 0; m_total = 0;
        end
      end
    end
  endtask

  task automatic check_model();
    int ec, es;
    ec = m_run ? m_total % m_len : 0;
    es = m_run ? m_total / m_len : 0;
    chk("busy",     int'(busy),     int'(m_run));
    chk("cnt",      int'(cnt),      ec);
    chk("cnt_rev",  int'(cnt_rev),  rev8(ec));
    chk("stage",    int'(stage),    es);
    chk("not_zero", int'(not_zero), int'(ec != 0));
    chk("wrap",     int'(wrap),     int'(m_wrap));
    chk("done",     int'(done),     int'(m_done));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic drive(input bit r, input bit s, input bit a, input bit v);
    rst_n = r; start = s; abort = a; valid = v;
  endtask

  initial begin
    vec_t tbl[$];
    int n, guard;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    thresh = 8'd0; num_stages = 3'd0;
    m_run = 0; m_total = 0; m_len = 1; m_ns = 0; m_wrap = 0; m_done = 0;

    // Basic run: thresh=3, two stages, eight valids, then idle checks
    tbl.push_back('{0,0,0,0, 3,1, 0,0,0,0,0});
    tbl.push_back('{1,1,0,0, 3,1, 1,0,0,0,0});
    tbl.push_back('{1,0,0,1, 3,1, 1,1,0,0,0});
    tbl.push_back('{1,0,0,1, 3,1, 1,2,0,0,0});
    tbl.push_back('{1,0,0,1, 3,1, 1,3,0,0,0});
    tbl.push_back('{1,0,0,1, 3,1, 1,0,1,1,0});
    tbl.push_back('{1,0,0,1, 3,1, 1,1,1,0,0});
    tbl.push_back('{1,0,0,1, 3,1, 1,2,1,0,0});
    tbl.push_back('{1,0,0,1, 3,1, 1,3,1,0,0});
    tbl.push_back('{1,0,0,1, 3,1, 0,0,0,1,1});
    tbl.push_back('{1,0,0,1, 3,1, 0,0,0,0,0});
    tbl.push_back('{1,1,1,1, 3,1, 0,0,0,0,0});
    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].start, tbl[i].abort, tbl[i].valid);
      thresh = 8'(tbl[i].thr); num_stages = 3'(tbl[i].ns);
      tick();
      chk($sformatf("vec%0d_busy", i),  int'(busy),  tbl[i].e_busy);
      chk($sformatf("vec%0d_cnt", i),   int'(cnt),   tbl[i].e_cnt);
      chk($sformatf("vec%0d_stage", i), int'(stage), tbl[i].e_stage);
      chk($sformatf("vec%0d_wrap", i),  int'(wrap),  tbl[i].e_wrap);
      chk($sformatf("vec%0d_done", i),  int'(done),  tbl[i].e_done);
    end

    // Gapped valid over a full 256-sample frame
    thresh = 8'd255; num_stages = 3'd0;
    drive(1, 1, 0, 0); tick();
    start = 0; n = 0; guard = 0;
    while (!done && guard < 3000) begin
      valid = ($urandom_range(99) < 40);
      if (valid) n++;
      tick();
      if (cnt == 8'd1) chk("rev_of_1", int'(cnt_rev), 8'h80);
      if (cnt == 8'd6) chk("rev_of_6", int'(cnt_rev), 8'h60);
      guard++;
    end
    chk("gap_done_seen", int'(done), 1);
    chk("gap_valids", n, 256);
    drive(1, 0, 0, 0); tick();

    // thresh=0, eight stages: every valid wraps, done on the 8th
    thresh = 8'd0; num_stages = 3'd7;
    drive(1, 1, 0, 0); tick();
    drive(1, 0, 0, 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t0_wrap", int'(wrap), 1);
      chk("t0_done", int'(done), int'(i == 8));
    end
    drive(1, 0, 0, 0); tick();

    // thresh change mid-run has no effect on the terminal count
    thresh = 8'd3; num_stages = 3'd0;
    drive(1, 1, 0, 0); tick();
    drive(1, 0, 0, 1); n = 0; guard = 0;
    while (!done && guard < 20) begin
      if (n == 2) thresh = 8'd1;
      n++; tick(); guard++;
    end
    chk("thr_change_valids", n, 4);
    drive(1, 0, 0, 0); tick();

    // Abort at cnt=5, stage=2 with a coincident valid, then immediate restart
    thresh = 8'd7; num_stages = 3'd3;
    drive(1, 1, 0, 0); tick();
    drive(1, 0, 0, 1);
    for (int i = 0; i < 21; i++) tick();
    chk("pre_abort_cnt", int'(cnt), 5);
    chk("pre_abort_stage", int'(stage), 2);
    drive(1, 0, 1, 1); tick();
    chk("abort_busy", int'(busy), 0);
    chk("abort_wrap", int'(wrap), 0);
    drive(1, 1, 0, 0); tick();
    chk("restart_busy", int'(busy), 1);
    drive(1, 0, 1, 0); tick();

    // Back-to-back with start held high
    thresh = 8'd1; num_stages = 3'd0;
    drive(1, 1, 0, 1); tick();
    guard = 0;
    while (!done && guard < 10) begin tick(); guard++; end
    chk("b2b_done_seen", int'(done), 1);
    chk("b2b_idle_busy", int'(busy), 0);
    tick();
    chk("b2b_restart_busy", int'(busy), 1);
    drive(1, 0, 1, 0); tick();

    // Reset mid-stage at cnt=7, stage=1; valids ignored afterwards
    thresh = 8'd15; num_stages = 3'd3;
    drive(1, 1, 0, 0); tick();
    drive(1, 0, 0, 1);
    for (int i = 0; i < 23; i++) tick();
    chk("pre_rst_cnt", int'(cnt), 7);
    chk("pre_rst_stage", int'(stage), 1);
    drive(0, 0, 0, 1); tick();
    chk("rst_busy", int'(busy), 0);
    drive(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_idle", int'(busy), 0);
    end

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(199) != 0);
      start = ($urandom_range(3) == 0);
      abort = ($urandom_range(39) == 0);
      valid = $urandom_range(1) == 1;
      thresh = ($urandom_range(4) == 0) ? 8'd0 : 8'($urandom_range(9));
      num_stages = 3'($urandom_range(7));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
